lcd_ram_reader: RTL and testbench

LCD_RAM_READER -- requirements
Module: lcd_ram_reader

---
 rtl/lcd_ram_reader_pkg.sv | 18 +
 rtl/lcd_ram_lat_cnt.sv | 26 ++
 rtl/lcd_ram_reader.sv | 108 ++++++++++
 tb/tb_lcd_ram_reader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ram_reader_pkg.sv
// Shared FSM encoding, RAM command codes and LCD geometry for the frame reader.
package lcd_ram_reader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_SEND,
      S_DONE
   } state_t;

   localparam logic [1:0] RAM_READ  = 2'b11;
   localparam logic [1:0] RAM_WRITE = 2'b10;
   localparam logic [1:0] RAM_IDLE  = 2'b00;

   localparam int LINE_LEN = 16;

endpackage

// File: rtl/lcd_ram_lat_cnt.sv
// Read-latency wait counter: 'last' flags the READ_LAT-th consecutive cycle of 'run'.
// Combinational 'last', no backpressure; clears whenever 'run' drops.
module lcd_ram_lat_cnt #(
   parameter int READ_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic last
);

   logic [1:0] cnt;

   assign last = run && (cnt == 2'(READ_LAT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!run || last) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 2'd1;
      end
   end

endmodule

// File: rtl/lcd_ram_reader.sv
// Scans DEPTH character cells from RAM to the LCD driver, one valid/ready beat per cell.
// READ_LAT+2 cycles per cell; char_ready low holds the beat, abort drops the scan at once.
module lcd_ram_reader
   import lcd_ram_reader_pkg::*;
#(
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 8,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_rw,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] char_data,
   output logic [ADDR_W-1:0] char_pos,
   output logic              char_eol,
   output logic              char_valid,
   input  logic              char_ready,
   output logic              busy,
   output logic              done
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] idx, idx_nxt;
   logic              lat_last;
   logic              hs;

   assign hs       = char_valid & char_ready;
   assign char_eol = (32'(char_pos) % LINE_LEN) == (LINE_LEN - 1);

   lcd_ram_lat_cnt #(
      .READ_LAT (READ_LAT)
   ) u_lat_cnt (
      .clk  (clk),
      .rst  (rst),
      .run  (state == S_WAIT),
      .last (lat_last)
   );

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      unique case (state)
         S_IDLE: if (start) begin
            state_nxt = S_REQ;
            idx_nxt   = '0;
         end
         S_REQ:  state_nxt = S_WAIT;
         S_WAIT: if (lat_last) state_nxt = S_SEND;
         S_SEND: if (hs) begin
            // last cell finishes the frame without issuing a wrap-around read
            if (idx == ADDR_W'(DEPTH - 1)) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_REQ;
               idx_nxt   = idx + 1'b1;
            end
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // abort beats start in IDLE and any handshake elsewhere
      if (abort) begin
         state_nxt = S_IDLE;
         idx_nxt   = idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr   <= '0;
         mem_rw     <= RAM_IDLE;
         char_data  <= '0;
         char_pos   <= '0;
         char_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         mem_rw <= (state_nxt == S_REQ) ? RAM_READ : RAM_IDLE;
         if (state_nxt == S_REQ) begin
            mem_addr <= idx_nxt;
         end
         if (state == S_WAIT && lat_last) begin
            char_data <= mem_rdata;
            char_pos  <= idx;
         end
         char_valid <= (state_nxt == S_SEND);
         busy       <= (state_nxt != S_IDLE);
         done       <= (state_nxt == S_DONE);
      end
   end

endmodule

// File: tb/tb_lcd_ram_reader.sv
// Randomized bench: cycle-level behavioural model for a READ_LAT=1 reader, plus a READ_LAT=3 pacing check.
module tb_lcd_ram_reader;

   localparam int LAT  = 1;
   localparam int LAT3 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, abort, char_ready;
   logic [4:0] mem_addr, char_pos;
   logic [1:0] mem_rw;
   logic [7:0] mem_rdata, char_data;
   logic       char_eol, char_valid, busy, done;

   logic       start3, abort3, ready3;
   logic [4:0] mem_addr3, char_pos3;
   logic [1:0] mem_rw3;
   logic [7:0] mem_rdata3, char_data3;
   logic       char_eol3, char_valid3, busy3, done3;

   logic [7:0] ram [32];
   logic [7:0] p3 [2];

   int total = 0;
   int bad   = 0;

   lcd_ram_reader #(.DEPTH(32), .ADDR_W(5), .DATA_W(8), .READ_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_rdata(mem_rdata),
      .char_data(char_data), .char_pos(char_pos), .char_eol(char_eol),
      .char_valid(char_valid), .char_ready(char_ready), .busy(busy), .done(done)
   );

   lcd_ram_reader #(.DEPTH(32), .ADDR_W(5), .DATA_W(8), .READ_LAT(LAT3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort3),
      .mem_addr(mem_addr3), .mem_rw(mem_rw3), .mem_rdata(mem_rdata3),
      .char_data(char_data3), .char_pos(char_pos3), .char_eol(char_eol3),
      .char_valid(char_valid3), .char_ready(ready3), .busy(busy3), .done(done3)
   );

   // RAM models: data is only meaningful exactly READ_LAT cycles after a read command
   always @(posedge clk) begin
      mem_rdata  <= (mem_rw == 2'b11) ? ram[mem_addr] : 8'($urandom);
      p3[0]      <= (mem_rw3 == 2'b11) ? ram[mem_addr3] : 8'($urandom);
      p3[1]      <= p3[0];
      mem_rdata3 <= p3[1];
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model of the READ_LAT=1 reader: cycles since launch, current cell, pending done
   bit         m_active = 1'b0;
   bit         m_done   = 1'b0;
   int         m_idx    = 0;
   int         m_since  = 0;
   bit         ev;
   int         done_cnt = 0;
   logic [7:0] hs_q[$];

   always @(negedge clk) begin
      if (rst) begin
         check("rst_addr", mem_addr, 0);
         check("rst_rw", mem_rw, 0);
         check("rst_data", char_data, 0);
         check("rst_pos", char_pos, 0);
         check("rst_valid", char_valid, 0);
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
         m_active = 1'b0;
         m_done   = 1'b0;
      end else begin
         ev = m_active && (m_since >= LAT + 2);
         check("mem_rw", mem_rw, (m_active && m_since == 1) ? 2'b11 : 2'b00);
         if (m_active && m_since == 1) check("mem_addr", mem_addr, m_idx);
         check("char_valid", char_valid, ev);
         check("busy", busy, m_active || m_done);
         check("done", done, m_done);
         if (ev) begin
            check("char_pos", char_pos, m_idx);
            check("char_data", char_data, ram[m_idx]);
            check("char_eol", char_eol, (m_idx % 16) == 15);
         end
         if (done) done_cnt++;
         if (abort) begin
            m_active = 1'b0;
            m_done   = 1'b0;
         end else if (m_done) begin
            m_done = 1'b0;
         end else if (!m_active) begin
            if (start) begin
               m_active = 1'b1;
               m_idx    = 0;
               m_since  = 1;
            end
         end else if (ev && char_ready) begin
            hs_q.push_back(char_data);
            if (m_idx == 31) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end else begin
               m_idx++;
               m_since = 1;
            end
         end else begin
            m_since++;
         end
      end
   end

   // READ_LAT=3 monitor: spacing of valid rises, cell order and line-end flags
   int  cyc3 = 0, last_rise = 0, rises3 = 0, done3_cnt = 0;
   bit  prev_v3 = 1'b0;
   int  eol_q[$];

   always @(negedge clk) begin
      cyc3++;
      if (!rst) begin
         check("rw3_never_write", (mem_rw3 == 2'b10), 0);
         if (char_valid3 && !prev_v3) begin
            rises3++;
            if (rises3 > 1) check("gap3", cyc3 - last_rise, 5);
            last_rise = cyc3;
            check("pos3", char_pos3, rises3 - 1);
         end
         if (char_valid3) begin
            check("data3", char_data3, ram[char_pos3]);
            check("eol3", char_eol3, (char_pos3 == 5'd15) || (char_pos3 == 5'd31));
            if (char_eol3) eol_q.push_back(int'(char_pos3));
         end
         if (done3) done3_cnt++;
      end
      prev_v3 = char_valid3;
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic frame(input int mode);
      int  n = 0;
      int  hold = 0;
      bit  held = 1'b0;
      bit  fired = 1'b0;
      bit  stop = 1'b0;
      hs_q.delete();
      done_cnt   = 0;
      char_ready = 1'b1;
      start      = 1'b1;
      cyc();
      start = 1'b0;
      while (n < 3000 && !stop) begin
         case (mode)
            1: begin
               if (char_valid && char_pos == 5'd3 && !held) begin
                  hold = 5;
                  held = 1'b1;
               end
               if (hold > 0) begin
                  char_ready = 1'b0;
                  hold--;
               end else begin
                  char_ready = ($urandom % 3) != 0;
               end
            end
            2: begin
               char_ready = 1'b1;
               if (char_valid && char_pos == 5'd7) begin
                  abort = 1'b1;
                  cyc();
                  abort = 1'b0;
                  check("abort_busy", busy, 0);
                  check("abort_done", done, 0);
                  check("abort_valid", char_valid, 0);
                  stop = 1'b1;
               end
            end
            3: begin
               char_ready = 1'($urandom % 2);
               if (char_valid && char_pos == 5'd20) begin
                  rst = 1'b1;
                  #1;
                  check("arst_valid", char_valid, 0);
                  check("arst_busy", busy, 0);
                  check("arst_pos", char_pos, 0);
                  check("arst_data", char_data, 0);
                  cyc();
                  cyc();
                  rst  = 1'b0;
                  stop = 1'b1;
               end
            end
            4: begin
               char_ready = 1'($urandom % 2);
               if (char_valid && char_pos == 5'd10 && !fired) begin
                  start = 1'b1;
                  fired = 1'b1;
               end else begin
                  start = 1'b0;
               end
            end
            default: char_ready = 1'b1;
         endcase
         if (!stop) begin
            cyc();
            n++;
            if (!busy) stop = 1'b1;
         end
      end
      start = 1'b0;
      check("frame_timeout", (n < 3000), 1);
      if (mode == 2) begin
         check("abort_chars", hs_q.size(), 7);
         check("abort_no_done", done_cnt, 0);
      end else if (mode == 3) begin
         check("rst_no_done", done_cnt, 0);
      end else begin
         check("frame_chars", hs_q.size(), 32);
         check("frame_done", done_cnt, 1);
         if (hs_q.size() == 32) begin
            check("char_at_1", hs_q[1], 8'd13);
            check("char_at_11", hs_q[11], 8'd11);
         end
      end
      cyc();
   endtask

   initial begin
      int n;
      for (int i = 0; i < 32; i++) ram[i] = 8'($urandom);
      ram[1]  = 8'd13;
      ram[11] = 8'd11;
      rst = 1'b1; start = 1'b0; abort = 1'b0; char_ready = 1'b0;
      start3 = 1'b0; abort3 = 1'b0; ready3 = 1'b1;
      repeat (3) cyc();
      check("reset_busy", busy, 0);
      check("reset_rw", mem_rw, 0);
      check("reset_valid", char_valid, 0);
      rst = 1'b0;
      cyc();

      frame(0);
      frame(1);
      frame(2);
      frame(0);
      frame(3);
      frame(0);
      frame(4);

      start3 = 1'b1;
      cyc();
      start3 = 1'b0;
      n = 0;
      while (busy3 && n < 3000) begin
         cyc();
         n++;
      end
      check("lat3_timeout", (n < 3000), 1);
      check("lat3_chars", rises3, 32);
      check("lat3_done", done3_cnt, 1);
      check("lat3_eol_count", eol_q.size(), 2);
      if (eol_q.size() == 2) begin
         check("lat3_eol_first", eol_q[0], 15);
         check("lat3_eol_second", eol_q[1], 31);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
